// File: rtl/ssd_capture.sv
// Recovers hex nibbles from a multiplexed active-low seven-segment bus and assembles them into display words.
// Optional build macro SSD_CAPTURE_ALT_GLYPH_EN also accepts the alternate 7 (0x27) and 9 (0x67) glyphs.
module ssd_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     an_n,
    input  logic [6:0]            seg_n,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   value,
    output logic                  value_valid,
    output logic                  frame_err,
    output logic [DIGITS-1:0]     digit_mask
);

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DIGITS-1:0]     an_q, anPrev_q;
    logic [6:0]            seg_q, segPrev_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   slots_q, slots_d;
    logic [DIGITS-1:0]     mask_q, mask_d;
    logic                  bad_q, bad_d;
    logic [4*DIGITS-1:0]   value_q, value_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    logic                  same;
    logic                  strobe;
    logic [DIGITS-1:0]     anLow;
    logic                  oneHot;
    logic                  decValid;
    logic [3:0]            decNibble;

    function automatic logic [4:0] decodeGlyph(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h3F: r = 5'h10;
            7'h06: r = 5'h11;
            7'h5B: r = 5'h12;
            7'h4F: r = 5'h13;
            7'h66: r = 5'h14;
            7'h6D: r = 5'h15;
            7'h7D: r = 5'h16;
            7'h07: r = 5'h17;
            7'h7F: r = 5'h18;
            7'h6F: r = 5'h19;
            7'h77: r = 5'h1A;
            7'h7C: r = 5'h1B;
            7'h39: r = 5'h1C;
            7'h5E: r = 5'h1D;
            7'h79: r = 5'h1E;
            7'h71: r = 5'h1F;
`ifdef SSD_CAPTURE_ALT_GLYPH_EN
            7'h27: r = 5'h17;
            7'h67: r = 5'h19;
`endif
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // The strobe fires on the single cycle the counter reaches its saturation value.
    always_comb begin
        same = ({an_q, seg_q} == {anPrev_q, segPrev_q});
        if (same) begin
            if (cnt_q == CNT_W'(STABLE_CYCLES)) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = CNT_W'(1);
        end
        strobe = (cnt_q != CNT_W'(STABLE_CYCLES)) && (cnt_d == CNT_W'(STABLE_CYCLES));
    end

    always_comb begin
        anLow               = ~an_q;
        oneHot              = (anLow != '0) && ((anLow & (anLow - 1'b1)) == '0);
        {decValid, decNibble} = decodeGlyph(~seg_q);
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        bad_d   = bad_q;
        slots_d = slots_q;
        value_d = value_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (clear) begin
            mask_d  = '0;
            bad_d   = 1'b0;
            state_d = COLLECT;
        end else if (state_q == EMIT) begin
            if (bad_q) begin
                err_d = 1'b1;
            end else begin
                value_d = slots_q;
                valid_d = 1'b1;
            end
            mask_d  = '0;
            bad_d   = 1'b0;
            state_d = COLLECT;
        end else if (strobe && oneHot) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (anLow[i]) begin
                    slots_d[4*i +: 4] = decNibble;
                    mask_d[i]         = 1'b1;
                end
            end
            bad_d = bad_q | ~decValid;
            if (mask_d == {DIGITS{1'b1}}) begin
                state_d = EMIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_q      <= '1;
            seg_q     <= '1;
            anPrev_q  <= '1;
            segPrev_q <= '1;
            cnt_q     <= '0;
            slots_q   <= '0;
            mask_q    <= '0;
            bad_q     <= 1'b0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            state_q   <= COLLECT;
        end else begin
            an_q      <= an_n;
            seg_q     <= seg_n;
            anPrev_q  <= an_q;
            segPrev_q <= seg_q;
            cnt_q     <= cnt_d;
            slots_q   <= slots_d;
            mask_q    <= mask_d;
            bad_q     <= bad_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            state_q   <= state_d;
        end
    end

    assign value       = value_q;
    assign value_valid = valid_q;
    assign frame_err   = err_q;
    assign digit_mask  = mask_q;

endmodule

// File: tb/tb_ssd_capture.sv
// Directed self-checking bench for ssd_capture with hand-computed expectations.
// Alternate-glyph expectations follow SSD_CAPTURE_ALT_GLYPH_EN.
module tb_ssd_capture;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ALT7  = 7'h58;
    localparam logic [6:0] SEG_ALT9  = 7'h18;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        clear;
    logic [15:0] value;
    logic        value_valid;
    logic        frame_err;
    logic [3:0]  digit_mask;

    int assertCount = 0;
    int failCount   = 0;
    int validSeen   = 0;
    int errSeen     = 0;

    ssd_capture #(
        .DIGITS(4),
        .STABLE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .an_n(an_n),
        .seg_n(seg_n),
        .clear(clear),
        .value(value),
        .value_valid(value_valid),
        .frame_err(frame_err),
        .digit_mask(digit_mask)
    );

    always #5 clk = ~clk;

    // Each cycle is sampled 1 ns after the edge; pulses are tallied and checked for exclusivity.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            validSeen += int'(value_valid);
            errSeen   += int'(frame_err);
            assertCount++;
            assert ((value_valid & frame_err) === 1'b0)
            else begin
                failCount++;
                $error("[TB] FAIL pulseExclusive observed valid=%0b err=%0b expected not both high",
                       value_valid, frame_err);
            end
        end
    endtask

    task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int cycles);
        an_n  = an;
        seg_n = seg;
        tick(cycles);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic showFrame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3);
        applyStimulus(4'b1110, s0, 8);
        applyStimulus(4'b1101, s1, 8);
        applyStimulus(4'b1011, s2, 8);
        applyStimulus(4'b0111, s3, 8);
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        an_n  = 4'b1111;
        seg_n = SEG_BLANK;
        tick(2);
        checkOutput("resetValue", 32'(value), 32'h0);
        checkOutput("resetValid", 32'(value_valid), 32'h0);
        checkOutput("resetErr", 32'(frame_err), 32'h0);
        checkOutput("resetMask", 32'(digit_mask), 32'h0);
        rst_n = 1'b1;
        tick(2);

        $display("[TB] good frame 0x1A3F");
        validSeen = 0;
        errSeen   = 0;
        applyStimulus(4'b1110, SEG_F, 8);
        checkOutput("frame1Mask0", 32'(digit_mask), 32'h1);
        applyStimulus(4'b1101, SEG_3, 8);
        checkOutput("frame1Mask1", 32'(digit_mask), 32'h3);
        applyStimulus(4'b1011, SEG_A, 8);
        checkOutput("frame1Mask2", 32'(digit_mask), 32'h7);
        applyStimulus(4'b0111, SEG_1, 8);
        checkOutput("frame1ValidCount", 32'(validSeen), 32'd1);
        checkOutput("frame1ErrCount", 32'(errSeen), 32'd0);
        checkOutput("frame1Value", 32'(value), 32'h1A3F);
        checkOutput("frame1MaskCleared", 32'(digit_mask), 32'h0);
        applyStimulus(4'b1111, SEG_BLANK, 4);

        $display("[TB] undecodable digit frame after reset");
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        checkOutput("rereset Value", 32'(value), 32'h0);
        validSeen = 0;
        errSeen   = 0;
        showFrame(SEG_F, SEG_3, SEG_BLANK, SEG_1);
        checkOutput("badFrameErrCount", 32'(errSeen), 32'd1);
        checkOutput("badFrameValidCount", 32'(validSeen), 32'd0);
        checkOutput("badFrameValue", 32'(value), 32'h0);
        checkOutput("badFrameMask", 32'(digit_mask), 32'h0);
        applyStimulus(4'b1111, SEG_BLANK, 4);

        $display("[TB] stability filter");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(4'b1110, (k % 2 == 0) ? SEG_0 : SEG_1, 3);
        end
        checkOutput("toggleNoSample", 32'(digit_mask), 32'h0);
        applyStimulus(4'b1110, SEG_0, 4);
        checkOutput("holdTooShort", 32'(digit_mask), 32'h0);
        tick(1);
        checkOutput("holdEarliestSample", 32'(digit_mask), 32'h1);
        tick(3);

        $display("[TB] non-one-hot selects and digit overwrite");
        validSeen = 0;
        errSeen   = 0;
        applyStimulus(4'b1100, SEG_1, 10);
        checkOutput("twoLowIgnored", 32'(digit_mask), 32'h1);
        applyStimulus(4'b1111, SEG_BLANK, 10);
        checkOutput("blankIgnored", 32'(digit_mask), 32'h1);
        applyStimulus(4'b1110, SEG_3, 8);
        applyStimulus(4'b1110, SEG_5, 8);
        checkOutput("resampleMask", 32'(digit_mask), 32'h1);
        applyStimulus(4'b1101, SEG_0, 8);
        applyStimulus(4'b1011, SEG_0, 8);
        applyStimulus(4'b0111, SEG_0, 8);
        checkOutput("overwriteValidCount", 32'(validSeen), 32'd1);
        checkOutput("overwriteErrCount", 32'(errSeen), 32'd0);
        checkOutput("overwriteValue", 32'(value), 32'h0005);
        applyStimulus(4'b1111, SEG_BLANK, 4);

        $display("[TB] clear mid-frame");
        validSeen = 0;
        errSeen   = 0;
        applyStimulus(4'b1110, SEG_7, 8);
        applyStimulus(4'b1101, SEG_7, 8);
        applyStimulus(4'b1011, SEG_7, 8);
        checkOutput("preClearMask", 32'(digit_mask), 32'h7);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        checkOutput("clearMask", 32'(digit_mask), 32'h0);
        checkOutput("clearKeepsValue", 32'(value), 32'h0005);
        tick(4);
        checkOutput("clearNoValid", 32'(validSeen), 32'd0);
        checkOutput("clearNoErr", 32'(errSeen), 32'd0);
        checkOutput("clearMaskHeld", 32'(digit_mask), 32'h0);
        showFrame(SEG_0, SEG_0, SEG_0, SEG_0);
        checkOutput("zeroFrameValidCount", 32'(validSeen), 32'd1);
        checkOutput("zeroFrameValue", 32'(value), 32'h0000);
        applyStimulus(4'b1111, SEG_BLANK, 4);

        $display("[TB] alternate glyphs");
        validSeen = 0;
        errSeen   = 0;
        showFrame(SEG_0, SEG_ALT7, SEG_0, SEG_ALT9);
`ifdef SSD_CAPTURE_ALT_GLYPH_EN
        checkOutput("altValidCount", 32'(validSeen), 32'd1);
        checkOutput("altErrCount", 32'(errSeen), 32'd0);
        checkOutput("altValue", 32'(value), 32'h9070);
`else
        checkOutput("altValidCount", 32'(validSeen), 32'd0);
        checkOutput("altErrCount", 32'(errSeen), 32'd1);
        checkOutput("altValue", 32'(value), 32'h0000);
`endif
        applyStimulus(4'b1111, SEG_BLANK, 4);

        $display("[TB] reset mid-frame");
        validSeen = 0;
        errSeen   = 0;
        applyStimulus(4'b1110, SEG_5, 8);
        checkOutput("midFrameMask", 32'(digit_mask), 32'h1);
        an_n  = 4'b1111;
        seg_n = SEG_BLANK;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        checkOutput("midResetMask", 32'(digit_mask), 32'h0);
        checkOutput("midResetValue", 32'(value), 32'h0);
        applyStimulus(4'b1101, SEG_0, 8);
        applyStimulus(4'b1011, SEG_0, 8);
        applyStimulus(4'b0111, SEG_0, 8);
        checkOutput("partialDiscardedMask", 32'(digit_mask), 32'hE);
        checkOutput("partialNoValid", 32'(validSeen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ssd_capture.md
Name: ssd_capture

Overview:
- Decodes a multiplexed, active-low seven-segment display bus (digit anodes plus segments) back into hex nibbles.
- Assembles one nibble per digit into a full display word.
- Used as a loopback monitor and checker for the display output path: on-board self-test and bench scoreboarding of the displayed value.
- Single clock domain; all outputs registered.

Parameters:
DIGITS, 4, number of multiplexed digits; output word is 4*DIGITS bits
STABLE_CYCLES, 4, consecutive identical registered input cycles required before a digit is sampled (min 2)
CNT_W, 3, stability counter width; must hold STABLE_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active low
an_n  input  DIGITS  digit select, active low; bit i low selects digit i
seg_n  input  7  segment lines g..a (bit6=g, bit0=a), active low
clear  input  1  synchronous abort of the current frame
value  output  4*DIGITS  last good frame; digit i occupies value[4i+3:4i]
value_valid  output  1  one-cycle pulse: value updated with a new good frame
frame_err  output  1  one-cycle pulse: frame completed containing an undecodable digit
digit_mask  output  DIGITS  digits captured so far in the current frame

Behaviour:
- Reset (rst_n=0 at a clk edge): value=0, value_valid=0, frame_err=0, digit_mask=0, bad flag=0, stability counter=0, input registers=all ones, FSM=COLLECT.
- Input stage: an_n and seg_n registered once (an_q, seg_q). All decisions use the registered values only.
- Stability:
  - If {an_q,seg_q} equals the previous cycle's value, the counter increments, saturating at STABLE_CYCLES.
  - Otherwise the counter resets to 1.
  - A sample strobe fires exactly once per stable period, in the cycle the counter transitions to STABLE_CYCLES.
  - Earliest strobe: STABLE_CYCLES+1 cycles after the input changes.
- Sample qualification:
  - Ignored when an_q is not one-hot-low (all high = blanking, or two or more low).
  - Otherwise digit i = index of the low bit.
- Decode (active-low pattern p = ~seg_q), standard hex glyphs:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7
  - 0x7F→8, 0x6F→9, 0x77→A, 0x7C→b, 0x39→C, 0x5E→d, 0x79→E, 0x71→F
  - Any other pattern is undecodable: nibble stored as 0 and the frame bad flag is set.
- On a qualified sample: nibble written to digit slot i; digit_mask[i] set.
  - A re-sample of an already-captured digit overwrites the slot (last wins).
  - A re-sample does not clear the bad flag.
- FSM:
  - COLLECT → EMIT when digit_mask becomes all ones.
  - EMIT lasts one cycle, then returns to COLLECT:
    - Bad flag clear: value ← assembled slots and value_valid=1.
    - Bad flag set: value unchanged and frame_err=1.
    - In either case digit_mask←0 and bad flag←0.
  - A sample strobe in the EMIT cycle is discarded.
- clear=1 (any state): digit_mask←0, bad←0, FSM→COLLECT, no pulses that cycle. value is retained. Priority is reset > clear > EMIT > sample.
- Reset mid-frame discards all partial data. value_valid and frame_err are never high in the same cycle.

Optional Feature:
SSD_CAPTURE_ALT_GLYPH_EN
- Defined: the decoder additionally accepts the alternate glyphs 0x27→7 (with segment f) and 0x67→9 (without segment d) as valid.
- Not defined: 0x27 and 0x67 are undecodable and set the bad flag.
- No other behaviour differs between the two builds.

Test Plan:
- Reset, then present digits 0..3 in turn, each held 8 cycles: an_n=4'b1110 seg_n=0x0E (F), 4'b1101 0x30 (3), 4'b1011 0x08 (A), 4'b0111 0x79 (1) → single value_valid pulse, value=0x1A3F, digit_mask returns to 0.
- Same sequence with digit 2 shown as seg_n=0x7F (blank pattern) → frame_err pulse, value remains 0x0000, no value_valid.
- Toggle seg_n every 3 cycles with STABLE_CYCLES=4 → no sample, digit_mask stays 0; hold 5+ cycles → digit_mask bit set.
- an_n=4'b1100 or 4'b1111 held 10 cycles → ignored, digit_mask unchanged; digit 0 shown twice (3 then 5) within a frame → nibble 0 = 5.
- Assert clear after 3 digits captured → digit_mask=0, no pulse; a full subsequent frame 0x0000 → value_valid, value=0x0000.
- seg_n=0x58 (~0x27) on digit 1 → with SSD_CAPTURE_ALT_GLYPH_EN nibble 1 = 7 and value_valid; without it frame_err.
